mem_port_arbiter: RTL

Shares the single-ported instruction/data SRAM between the IF stage's fetch and the MEM stage's loads/stores. Grants one requester at a time and holds the SRAM port for a fixed access latency. Returns read data with a one-cycle ready pulse. Generates the freeze signals that hold the IF stage and the whole pipeline while their access is outstanding.

---
 rtl/mem_port_arbiter.sv | 122 ++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared single-ported SRAM between instruction fetch and data load/store.
// Optional wait-cycle performance counters are enabled by defining MEM_ARB_PERF_CNT_EN.
module mem_port_arbiter #(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ifReq,
    input  logic [ADDR_W-1:0] ifAddr,
    output logic [DATA_W-1:0] ifRdata,
    output logic              ifReady,
    input  logic              memRead,
    input  logic              memWrite,
    input  logic [ADDR_W-1:0] memAddr,
    input  logic [DATA_W-1:0] memWdata,
    output logic [DATA_W-1:0] memRdata,
    output logic              memReady,
    output logic              sramEn,
    output logic              sramWe,
    output logic [ADDR_W-1:0] sramAddr,
    output logic [DATA_W-1:0] sramWdata,
    input  logic [DATA_W-1:0] sramRdata,
    output logic              freezeIf,
    output logic              freezePipe
`ifdef MEM_ARB_PERF_CNT_EN
    ,
    output logic [31:0]       ifWaitCnt,
    output logic [31:0]       memWaitCnt
`endif
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic {SIDE_IF = 1'b0, SIDE_MEM = 1'b1} side_t;

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    state_t     state;
    side_t      grant;
    side_t      last_grant;
    logic [3:0] cnt;

    logic mem_req;
    logic any_req;
    logic pick_mem;

    assign mem_req  = memRead | memWrite;
    assign any_req  = ifReq | mem_req;
    // On a tie the side that did not win last time gets the port.
    assign pick_mem = mem_req & (~ifReq | (last_grant == SIDE_IF));

    assign freezePipe = mem_req & ~memReady;
    assign freezeIf   = (ifReq & ~ifReady) | freezePipe;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= SIDE_IF;
            last_grant <= SIDE_IF;
            cnt        <= '0;
            sramEn     <= 1'b0;
            sramWe     <= 1'b0;
            sramAddr   <= '0;
            sramWdata  <= '0;
            ifRdata    <= '0;
            memRdata   <= '0;
            ifReady    <= 1'b0;
            memReady   <= 1'b0;
        end else begin
            ifReady  <= 1'b0;
            memReady <= 1'b0;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        grant    <= pick_mem ? SIDE_MEM : SIDE_IF;
                        sramAddr <= pick_mem ? memAddr : ifAddr;
                        sramWe   <= pick_mem & memWrite;
                        if (pick_mem) sramWdata <= memWdata;
                        cnt      <= LAT_M1;
                        sramEn   <= 1'b1;
                        state    <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == 4'd0) begin
                        sramEn     <= 1'b0;
                        sramWe     <= 1'b0;
                        last_grant <= grant;
                        if (grant == SIDE_IF) begin
                            ifRdata <= sramRdata;
                            ifReady <= 1'b1;
                        end else begin
                            if (!sramWe) memRdata <= sramRdata;
                            memReady <= 1'b1;
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                // Ready is visible here; no grant so a still-held request is not reissued.
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MEM_ARB_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ifWaitCnt  <= '0;
            memWaitCnt <= '0;
        end else begin
            if (ifReq && !ifReady && !(&ifWaitCnt)) ifWaitCnt <= ifWaitCnt + 32'd1;
            if (freezePipe && !(&memWaitCnt)) memWaitCnt <= memWaitCnt + 32'd1;
        end
    end
`endif

endmodule
